// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer
// Turns whole frames from a valid/ready byte source into a GMII transmit
// byte stream: preamble + SFD, payload zero-padded to MIN_DATA bytes,
// CRC-32 FCS (least-significant byte first), then an enforced idle gap.
// If the source runs dry mid-payload, one error byte is sent with txer set
// and the rest of that frame is swallowed from the source.
//
// Ports
//   reset       async active-high reset
//   user_clk    byte clock, one GMII byte per cycle
//   enable      allows a new frame to start (looked at only while idle)
//   s_data      payload byte
//   s_valid     s_data valid
//   s_last      last payload byte of the frame
//   s_ready     byte accepted when s_valid & s_ready (DATA or DROP only)
//   txd         GMII transmit data (registered)
//   txen        GMII transmit enable (registered)
//   txer        GMII transmit error (registered)
//   busy        high whenever a frame, drop or gap is in progress
//   frame_done  one-cycle pulse while the final FCS byte is on txd
//   underrun    one-cycle pulse while txer is driven
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_DATA     = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       reset,
  input  logic       user_clk,
  input  logic       enable,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       txen,
  output logic       txer,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    PAD,
    FCS,
    DROP,
    IFG
  } state_t;

  localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_DATA);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  state_t      state;
  logic [31:0] crc;
  logic [3:0]  pre_cnt;
  logic [15:0] byte_cnt;
  logic [1:0]  fcs_cnt;
  logic [7:0]  ifg_cnt;

  // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  logic [15:0] byte_cnt_inc;
  logic [31:0] crc_data;
  logic [31:0] crc_pad;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  // Payload byte count saturates so very long frames never wrap back below
  // MIN_DATA.
  assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  assign crc_data     = crc32_byte(crc, s_data);
  assign crc_pad      = crc32_byte(crc, 8'h00);
  assign fcs          = ~crc;

  always_comb begin
    fcs_byte = fcs[7:0];
    case (fcs_cnt)
      2'd0: fcs_byte = fcs[7:0];
      2'd1: fcs_byte = fcs[15:8];
      2'd2: fcs_byte = fcs[23:16];
      2'd3: fcs_byte = fcs[31:24];
      default: fcs_byte = fcs[7:0];
    endcase
  end

  assign s_ready = (state == DATA) || (state == DROP);
  assign busy    = (state != IDLE);

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      txd        <= 8'h00;
      txen       <= 1'b0;
      txer       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      crc        <= 32'hFFFFFFFF;
      pre_cnt    <= 4'd0;
      byte_cnt   <= 16'd0;
      fcs_cnt    <= 2'd0;
      ifg_cnt    <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      txer       <= 1'b0;
      case (state)
        IDLE: begin
          txd  <= 8'h00;
          txen <= 1'b0;
          if (enable && s_valid) begin
            txd     <= 8'h55;
            txen    <= 1'b1;
            pre_cnt <= 4'd1;
            state   <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          if (pre_cnt < PRE_LAST) begin
            txd     <= 8'h55;
            pre_cnt <= pre_cnt + 4'd1;
          end else begin
            txd      <= 8'hD5;
            crc      <= 32'hFFFFFFFF;
            byte_cnt <= 16'd0;
            fcs_cnt  <= 2'd0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (s_valid) begin
            txd      <= s_data;
            crc      <= crc_data;
            byte_cnt <= byte_cnt_inc;
            if (s_last) begin
              state <= (byte_cnt_inc < MIN_CNT) ? PAD : FCS;
            end
          end else begin
            // Source ran dry: flag the frame as bad on the wire.
            txd      <= 8'h00;
            txen     <= 1'b1;
            txer     <= 1'b1;
            underrun <= 1'b1;
            state    <= DROP;
          end
        end
        PAD: begin
          txd      <= 8'h00;
          crc      <= crc_pad;
          byte_cnt <= byte_cnt_inc;
          if (byte_cnt_inc >= MIN_CNT) begin
            state <= FCS;
          end
        end
        FCS: begin
          txd     <= fcs_byte;
          fcs_cnt <= fcs_cnt + 2'd1;
          if (fcs_cnt == 2'd3) begin
            frame_done <= 1'b1;
            ifg_cnt    <= 8'd0;
            state      <= IFG;
          end
        end
        DROP: begin
          txd  <= 8'h00;
          txen <= 1'b0;
          if (s_valid && s_last) begin
            ifg_cnt <= 8'd0;
            state   <= IFG;
          end
        end
        IFG: begin
          txd  <= 8'h00;
          txen <= 1'b0;
          if (ifg_cnt >= IFG_LAST) begin
            ifg_cnt <= 8'd0;
            state   <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
`timescale 1ns/1ps
module tb_gmii_tx_framer;

  localparam int PRE = 7;
  localparam int MIN = 60;
  localparam int IFG = 12;

  logic       reset;
  logic       user_clk;
  logic       enable;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] txd;
  logic       txen;
  logic       txer;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  gmii_tx_framer #(
    .PREAMBLE_LEN(PRE),
    .MIN_DATA(MIN),
    .IFG_BYTES(IFG)
  ) dut (
    .reset(reset),
    .user_clk(user_clk),
    .enable(enable),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .txd(txd),
    .txen(txen),
    .txer(txer),
    .busy(busy),
    .frame_done(frame_done),
    .underrun(underrun)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;

  // Expected wire bytes while txen is high, and captured wire samples.
  typedef struct packed { logic [7:0] d; logic er; logic fd; logic ur; } rec_t;
  typedef struct packed { logic [7:0] d; logic en; logic er; logic fd; logic ur; } cap_t;

  rec_t       exp_q[$];
  int         exp_len_q[$];
  int         exp_gap_q[$];
  cap_t       cap_q[$];
  bit         cap_on = 1'b0;
  bit         rand_en = 1'b0;
  logic [7:0] payload[$];
  logic [31:0] crc_tab[256];

  always @(negedge user_clk) begin
    if (cap_on) cap_q.push_back({txd, txen, txer, frame_done, underrun});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    return (c >> 8) ^ crc_tab[c[7:0] ^ b];
  endfunction

  function automatic void push_rec(input logic [7:0] d, input logic er, input logic fd, input logic ur);
    rec_t r;
    r.d = d; r.er = er; r.fd = fd; r.ur = ur;
    exp_q.push_back(r);
  endfunction

  // Reference: what the wire should carry for this payload, and the minimum
  // txen-low gap that must follow before the next frame.
  function automatic void model_expect(input int n, input int gap_at);
    int start;
    int body;
    logic [31:0] c;
    logic [7:0]  b;
    start = exp_q.size();
    for (int k = 0; k < PRE; k++) push_rec(8'h55, 1'b0, 1'b0, 1'b0);
    push_rec(8'hD5, 1'b0, 1'b0, 1'b0);
    if (gap_at >= 0) begin
      for (int k = 0; k < gap_at; k++) push_rec(payload[k], 1'b0, 1'b0, 1'b0);
      push_rec(8'h00, 1'b1, 1'b0, 1'b1);
      exp_gap_q.push_back((n - gap_at) + IFG);
    end else begin
      body = (n > MIN) ? n : MIN;
      c = 32'hFFFFFFFF;
      for (int k = 0; k < body; k++) begin
        b = (k < n) ? payload[k] : 8'h00;
        c = crc_next(c, b);
        push_rec(b, 1'b0, 1'b0, 1'b0);
      end
      c = ~c;
      for (int j = 0; j < 4; j++) push_rec(c[8*j +: 8], 1'b0, (j == 3), 1'b0);
      exp_gap_q.push_back(IFG);
    end
    exp_len_q.push_back(exp_q.size() - start);
  endfunction

  task automatic make_payload(input int n, input int pat);
    payload.delete();
    for (int k = 0; k < n; k++) begin
      case (pat)
        0:       payload.push_back(8'(k));
        1:       payload.push_back(8'($urandom));
        default: payload.push_back(8'h01);
      endcase
    end
  endtask

  // Source: streams the payload; at index gap_at it withholds s_valid for
  // one DATA cycle, then streams the remainder.
  task automatic drive_frame(input int n, input int gap_at);
    int i;
    int cyc;
    bit fire;
    bit gapped;
    i = 0; cyc = 0; gapped = 1'b0;
    while (i < n) begin
      enable = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i == gap_at && !gapped && s_ready) begin
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; gapped = 1'b1;
      end else begin
        s_valid = 1'b1; s_data = payload[i]; s_last = (i == n - 1);
      end
      fire = s_valid && s_ready;
      @(negedge user_clk);
      if (fire) i++;
      cyc++;
      if (cyc > 5000) begin
        checks++; errors++;
        $display("FAIL drive_timeout: consumed %0d of %0d bytes", i, n);
        break;
      end
    end
  endtask

  task automatic run_frame(input int n, input int gap_at, input int pat);
    make_payload(n, pat);
    model_expect(n, gap_at);
    drive_frame(n, gap_at);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    s_valid = 1'b0; s_last = 1'b0; enable = 1'b1;
    @(negedge user_clk);
    while (busy && c < 3000) begin
      @(negedge user_clk);
      c++;
    end
    check("idle_timeout_busy", busy, 1'b0);
    repeat (2) @(negedge user_clk);
  endtask

  task automatic scn_begin();
    cap_q.delete(); exp_q.delete(); exp_len_q.delete(); exp_gap_q.delete();
    cap_on = 1'b1;
  endtask

  task automatic analyze(input string name, input bit exact, output int fs, output int fl);
    int s, base, prev_end, start, blen, nf, bad, fb, gap, stray, extra, lim;
    s = 0; base = 0; prev_end = 0; stray = 0; extra = 0; fs = 0; fl = 0;
    nf = exp_len_q.size();
    for (int f = 0; f < nf; f++) begin
      while (s < cap_q.size() && !cap_q[s].en) begin
        if (cap_q[s].fd || cap_q[s].ur) stray++;
        s++;
      end
      checks++;
      if (s >= cap_q.size()) begin
        errors++;
        $display("FAIL %s_burst%0d: no txen burst seen, required %0d bytes", name, f, exp_len_q[f]);
        break;
      end
      if (f > 0) begin
        gap = s - prev_end - 1;
        checks++;
        if (exact ? (gap != exp_gap_q[f-1]) : (gap < exp_gap_q[f-1])) begin
          errors++;
          $display("FAIL %s_gap%0d: txen low %0d cycles, required %s%0d", name, f, gap,
                   exact ? "" : ">=", exp_gap_q[f-1]);
        end
      end
      start = s;
      while (s < cap_q.size() && cap_q[s].en) s++;
      blen = s - start;
      if (f == 0) begin fs = start; fl = blen; end
      check({name, "_burst_len"}, blen, exp_len_q[f]);
      lim = (blen < exp_len_q[f]) ? blen : exp_len_q[f];
      bad = 0; fb = -1;
      for (int k = 0; k < lim; k++) begin
        if ({cap_q[start+k].d, cap_q[start+k].er, cap_q[start+k].fd, cap_q[start+k].ur}
            !== exp_q[base+k]) begin
          bad++;
          if (fb < 0) fb = k;
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s_stream%0d: %0d wrong bytes, first at %0d: got d=%02h er=%0b fd=%0b ur=%0b, required d=%02h er=%0b fd=%0b ur=%0b",
                 name, f, bad, fb, cap_q[start+fb].d, cap_q[start+fb].er, cap_q[start+fb].fd,
                 cap_q[start+fb].ur, exp_q[base+fb].d, exp_q[base+fb].er, exp_q[base+fb].fd,
                 exp_q[base+fb].ur);
      end
      $display("%s frame %0d: txen burst %0d cycles (model %0d), %0d byte differences",
               name, f, blen, exp_len_q[f], bad);
      base += exp_len_q[f];
      prev_end = s - 1;
    end
    while (s < cap_q.size()) begin
      if (cap_q[s].en) extra++;
      if (cap_q[s].fd || cap_q[s].ur) stray++;
      s++;
    end
    check({name, "_stray_activity"}, stray + extra, 0);
  endtask

  task automatic scn_end(input string name, input bit exact, output int fs, output int fl);
    wait_idle();
    cap_on = 1'b0;
    analyze(name, exact, fs, fl);
  endtask

  function automatic int count_fd();
    int c = 0;
    foreach (cap_q[k]) if (cap_q[k].fd) c++;
    return c;
  endfunction

  function automatic int count_ur();
    int c = 0;
    foreach (cap_q[k]) if (cap_q[k].ur) c++;
    return c;
  endfunction

  typedef struct {
    int    len;
    int    gap_at;
    int    pat;
    int    exp_burst;
    int    exp_fd;
    int    exp_ur;
    string name;
  } vec_t;

  vec_t vecs[8];
  int   fs, fl, n, g, nf, nbytes, cnt;
  bit   fire;
  logic [31:0] resid;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = 32'(i);
      for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      crc_tab[i] = v;
    end

    vecs[0] = '{1,   -1, 2,  72, 1, 0, "single_byte"};
    vecs[1] = '{100, -1, 0, 112, 1, 0, "incr100"};
    vecs[2] = '{60,  -1, 1,  72, 1, 0, "rand60"};
    vecs[3] = '{59,  -1, 1,  72, 1, 0, "rand59"};
    vecs[4] = '{61,  -1, 1,  73, 1, 0, "rand61"};
    vecs[5] = '{80,  20, 0,  29, 0, 1, "underrun_at20"};
    vecs[6] = '{5,    0, 1,   9, 0, 1, "underrun_first"};
    vecs[7] = '{200, -1, 1, 212, 1, 0, "rand200"};

    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge user_clk);
    check("reset_txd", txd, 8'h00);
    check("reset_txen", txen, 1'b0);
    check("reset_txer", txer, 1'b0);
    check("reset_pulses", {frame_done, underrun}, 2'b00);
    check("reset_busy_ready", {busy, s_ready}, 2'b00);
    reset = 1'b0;
    repeat (2) @(negedge user_clk);

    // Table-driven single frames.
    for (int v = 0; v < 8; v++) begin
      scn_begin();
      run_frame(vecs[v].len, vecs[v].gap_at, vecs[v].pat);
      scn_end(vecs[v].name, 1'b1, fs, fl);
      check({vecs[v].name, "_txen_cycles"}, fl, vecs[v].exp_burst);
      check({vecs[v].name, "_frame_done_cnt"}, count_fd(), vecs[v].exp_fd);
      check({vecs[v].name, "_underrun_cnt"}, count_ur(), vecs[v].exp_ur);
      if (v == 0 && fl == 72) begin
        check("single_byte_first_payload", cap_q[fs+8].d, 8'h01);
        check("single_byte_done_cycle", cap_q[fs+71].fd, 1'b1);
        resid = 32'hFFFFFFFF;
        for (int k = 8; k < 72; k++) resid = crc_next(resid, cap_q[fs+k].d);
        check("single_byte_crc_residue", resid, 32'hDEBB20E3);
      end
    end

    // Two 64-byte frames with s_valid held high.
    scn_begin();
    run_frame(64, -1, 1);
    run_frame(64, -1, 1);
    scn_end("b2b64", 1'b1, fs, fl);
    check("b2b64_frame_done_cnt", count_fd(), 2);

    // Underrun then an immediately following good frame: the drop swallows
    // the remaining 60 bytes, then the 12-cycle gap.
    scn_begin();
    run_frame(80, 20, 1);
    run_frame(64, -1, 1);
    scn_end("drop_then_frame", 1'b1, fs, fl);
    check("drop_then_frame_underrun_cnt", count_ur(), 1);

    // Reset asserted mid-payload.
    make_payload(80, 1);
    enable = 1'b1; s_valid = 1'b1; s_last = 1'b0;
    nbytes = 0; cnt = 0;
    while (nbytes < 30 && cnt < 500) begin
      s_data = payload[nbytes];
      fire = s_ready;
      @(negedge user_clk);
      if (fire) nbytes++;
      cnt++;
    end
    check("rst_mid_bytes_sent", nbytes, 30);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_txen", txen, 1'b0);
    check("rst_mid_txer", txer, 1'b0);
    check("rst_mid_txd", txd, 8'h00);
    check("rst_mid_pulses", {frame_done, underrun}, 2'b00);
    s_valid = 1'b0;
    @(negedge user_clk);
    reset = 1'b0;
    @(negedge user_clk);
    check("rst_mid_after_release", {txen, busy, frame_done, underrun}, 4'b0000);
    scn_begin();
    run_frame(70, -1, 1);
    scn_end("after_reset", 1'b1, fs, fl);
    check("after_reset_frame_done_cnt", count_fd(), 1);

    // enable gates the start of a frame.
    scn_begin();
    make_payload(40, 1);
    model_expect(40, -1);
    enable = 1'b0; s_valid = 1'b1; s_data = payload[0]; s_last = 1'b0;
    repeat (3) begin
      @(negedge user_clk);
      check("en_low_outputs", {txen, s_ready, busy}, 3'b000);
    end
    enable = 1'b1;
    @(negedge user_clk);
    check("en_high_start", {txen, txd}, {1'b1, 8'h55});
    drive_frame(40, -1);
    scn_end("enable_gate", 1'b1, fs, fl);

    // Randomized frames, random enable toggling, random underruns.
    rand_en = 1'b1;
    for (int r = 0; r < 5; r++) begin
      scn_begin();
      nf = int'($urandom_range(1, 3));
      for (int f = 0; f < nf; f++) begin
        n = int'($urandom_range(1, 130));
        g = -1;
        if ($urandom_range(0, 3) == 0) g = int'($urandom_range(0, n - 1));
        run_frame(n, g, 1);
      end
      scn_end("random", 1'b0, fs, fl);
    end
    rand_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
